mem_port_arbiter: RTL and testbench

- Shares the single-port access path of the 64-word instruction/data memory between two requesters: A (CPU datapath load/store) and B (loader/debug port that writes program words or polls the output word at address 0xFC).
- Grants at most one access per cycle, using round-robin with an optional bounded lock for bursts.
- Drives the memory's write_enable, write_addr and write_data signals, plus read port 1 (read_enable_1, read_addr_1, read_data_1).
- Returns registered read data to the winning requester.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory access port between requester A (CPU)
// and requester B (loader/debug) with round-robin and a bounded burst lock.
module mem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_lock,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_read_data
);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              a_win_s, b_win_s, idle_a_s;
  logic              a_gnt_s, b_gnt_s, any_gnt_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] h);
    if (h == HOLD_LAST) begin
      sat_inc = h;
    end else begin
      sat_inc = h + HOLD_W'(1);
    end
  endfunction

  // Winner selection: an owner keeps the port unless its hold budget is spent
  // and the other side waits; a non-requesting owner falls back to idle rules.
  always_comb begin
    idle_a_s = a_req && (!b_req || last_b_q);
    a_win_s  = 1'b0;
    b_win_s  = 1'b0;
    case (state_q)
      OWN_A: begin
        if (a_req && !(hold_q == HOLD_LAST && b_req)) begin
          a_win_s = 1'b1;
        end else begin
          b_win_s = b_req;
        end
      end
      OWN_B: begin
        if (b_req && !(hold_q == HOLD_LAST && a_req)) begin
          b_win_s = 1'b1;
        end else begin
          a_win_s = a_req;
        end
      end
      default: begin
        a_win_s = idle_a_s;
        b_win_s = b_req && !idle_a_s;
      end
    endcase
  end

  assign a_gnt_s   = a_win_s && reset_n;
  assign b_gnt_s   = b_win_s && reset_n;
  assign any_gnt_s = a_gnt_s || b_gnt_s;

  // hold counts grants after the one that took ownership, so a contested
  // burst lasts MAX_HOLD grants before the hand-over.
  always_comb begin
    state_d  = IDLE;
    hold_d   = '0;
    last_b_d = last_b_q;
    if (a_gnt_s) begin
      last_b_d = 1'b0;
      if (a_lock) begin
        state_d = OWN_A;
        hold_d  = (state_q == OWN_A) ? sat_inc(hold_q) : '0;
      end else begin
        state_d = IDLE;
        hold_d  = '0;
      end
    end else if (b_gnt_s) begin
      last_b_d = 1'b1;
      if (b_lock) begin
        state_d = OWN_B;
        hold_d  = (state_q == OWN_B) ? sat_inc(hold_q) : '0;
      end else begin
        state_d = IDLE;
        hold_d  = '0;
      end
    end else begin
      state_d = IDLE;
      hold_d  = '0;
    end
  end

  assign sel_we_s    = b_gnt_s ? b_we    : a_we;
  assign sel_addr_s  = b_gnt_s ? b_addr  : a_addr;
  assign sel_wdata_s = b_gnt_s ? b_wdata : a_wdata;

  assign a_gnt            = a_gnt_s;
  assign b_gnt            = b_gnt_s;
  assign mem_write_enable = any_gnt_s && sel_we_s;
  assign mem_write_addr   = mem_write_enable ? sel_addr_s : '0;
  assign mem_write_data   = mem_write_enable ? sel_wdata_s : '0;
  assign mem_read_enable  = any_gnt_s && !sel_we_s;
  assign mem_read_addr    = mem_read_enable ? sel_addr_s : '0;

  // Arbitration state and registered read returns.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      hold_q     <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      hold_q     <= hold_d;
      a_rvalid_q <= a_gnt_s && !a_we;
      b_rvalid_q <= b_gnt_s && !b_we;
      if (a_gnt_s && !a_we) begin
        a_rdata_q <= mem_read_data;
      end
      if (b_gnt_s && !b_we) begin
        b_rdata_q <= mem_read_data;
      end
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rvalid = b_rvalid_q;
  assign b_rdata  = b_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected grants,
// writes and read data; a negedge monitor pops and compares.
module tb_mem_port_arbiter;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_write_enable, mem_read_enable;
  logic [7:0]  mem_write_addr, mem_read_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic [31:0] mem [64];
  logic        mem_load;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  logic [39:0] exp_w_q[$];
  logic [1:0]  exp_g_q[$];

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_read_enable(mem_read_enable),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data)
  );

  // 64-word memory: word i holds i*0x01010101 except word 2 = 0x22110000
  assign mem_read_data = mem[mem_read_addr[7:2]];
  always @(posedge clock) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h01010101;
      mem[2] <= 32'h22110000;
    end else if (mem_write_enable) begin
      mem[mem_write_addr[7:2]] <= mem_write_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clock) begin
    if (reset_n) begin
      if (exp_g_q.size() > 0) chk("grant_ab", {62'd0, a_gnt, b_gnt}, {62'd0, exp_g_q.pop_front()});
      if (a_rvalid) begin
        if (exp_a_q.size() == 0) chk("a_rvalid_unexpected", {63'd0, a_rvalid}, 64'd0);
        else chk("a_rdata", {32'd0, a_rdata}, {32'd0, exp_a_q.pop_front()});
      end
      if (b_rvalid) begin
        if (exp_b_q.size() == 0) chk("b_rvalid_unexpected", {63'd0, b_rvalid}, 64'd0);
        else chk("b_rdata", {32'd0, b_rdata}, {32'd0, exp_b_q.pop_front()});
      end
      if (mem_write_enable) begin
        if (exp_w_q.size() == 0) chk("mem_we_unexpected", {63'd0, mem_write_enable}, 64'd0);
        else chk("mem_write", {24'd0, mem_write_addr, mem_write_data}, {24'd0, exp_w_q.pop_front()});
      end else begin
        chk("idle_write_bus_zero", {24'd0, mem_write_addr, mem_write_data}, 64'd0);
      end
    end
  end

  task automatic drv_a(input logic req, input logic we, input logic [7:0] addr,
                       input logic [31:0] wd, input logic lock);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd; a_lock = lock;
  endtask

  task automatic drv_b(input logic req, input logic we, input logic [7:0] addr,
                       input logic [31:0] wd, input logic lock);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd; b_lock = lock;
  endtask

  task automatic cyc(input logic [1:0] g);
    exp_g_q.push_back(g);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cyc();
    drv_a(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    drv_b(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    cyc(2'b00);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset_n  = 1'b0;
    mem_load = 1'b1;
    drv_a(1'b1, 1'b1, 8'h10, 32'hFFFF_FFFF, 1'b1);
    drv_b(1'b1, 1'b0, 8'h0C, 32'h0, 1'b0);
    #3;
    chk("rst_a_gnt", {63'd0, a_gnt}, 64'd0);
    chk("rst_b_gnt", {63'd0, b_gnt}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_write_enable}, 64'd0);
    chk("rst_mem_re", {63'd0, mem_read_enable}, 64'd0);
    chk("rst_rvalid", {62'd0, a_rvalid, b_rvalid}, 64'd0);
    chk("rst_rdata", {a_rdata, b_rdata}, 64'd0);
    @(posedge clock);
    #1;
    mem_load = 1'b0;
    drv_a(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    drv_b(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    #5;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Test 1: lone A read of word 2
    drv_a(1'b1, 1'b0, 8'h08, 32'h0, 1'b0); exp_a_q.push_back(32'h22110000); cyc(2'b10);
    idle_cyc();

    // Reset pulse between edges clears read data; then test 2: unlocked tie alternation
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
    chk("rst_pulse_a_rdata", {32'd0, a_rdata}, 64'd0);
    @(posedge clock);
    #1;
    drv_a(1'b1, 1'b1, 8'h40, 32'hA0A00001, 1'b0); drv_b(1'b1, 1'b0, 8'h0C, 32'h0, 1'b0);
    exp_w_q.push_back({8'h40, 32'hA0A00001}); cyc(2'b10);
    drv_a(1'b1, 1'b1, 8'h44, 32'hA0A00002, 1'b0);
    exp_b_q.push_back(32'h03030303); cyc(2'b01);
    drv_b(1'b1, 1'b0, 8'h40, 32'h0, 1'b0);
    exp_w_q.push_back({8'h44, 32'hA0A00002}); cyc(2'b10);
    drv_a(1'b1, 1'b1, 8'h48, 32'hA0A00003, 1'b0);
    exp_b_q.push_back(32'hA0A00001); cyc(2'b01);
    drv_b(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    exp_w_q.push_back({8'h48, 32'hA0A00003}); cyc(2'b10);
    idle_cyc();

    // Test 3: B locked write of the output word, then read it back
    drv_b(1'b1, 1'b1, 8'hFC, 32'hDEADBEEF, 1'b1);
    exp_w_q.push_back({8'hFC, 32'hDEADBEEF}); cyc(2'b01);
    drv_b(1'b1, 1'b0, 8'hFC, 32'h0, 1'b0);
    exp_b_q.push_back(32'hDEADBEEF); cyc(2'b01);
    idle_cyc();

    // A alone so that A is last winner, then test 4: B locked vs A waiting
    drv_a(1'b1, 1'b0, 8'h04, 32'h0, 1'b0); exp_a_q.push_back(32'h01010101); cyc(2'b10);
    drv_a(1'b1, 1'b1, 8'h20, 32'h5A5A0001, 1'b0); drv_b(1'b1, 1'b0, 8'h10, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) begin
        exp_w_q.push_back({a_addr, a_wdata});
        cyc(2'b10);
        drv_a(1'b1, 1'b1, 8'h24, 32'h5A5A0002, 1'b0);
      end else begin
        exp_b_q.push_back(32'h04040404);
        cyc(2'b01);
      end
    end
    idle_cyc();
    drv_a(1'b1, 1'b0, 8'h20, 32'h0, 1'b0); exp_a_q.push_back(32'h5A5A0001); cyc(2'b10);
    drv_a(1'b1, 1'b0, 8'h24, 32'h0, 1'b0); exp_a_q.push_back(32'h5A5A0002); cyc(2'b10);
    idle_cyc();

    // Test 5: lone locked B is never capped; A arriving later is served at once
    drv_b(1'b1, 1'b0, 8'h14, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_b_q.push_back(32'h05050505);
      cyc(2'b01);
    end
    drv_a(1'b1, 1'b0, 8'h08, 32'h0, 1'b0); exp_a_q.push_back(32'h22110000); cyc(2'b10);
    drv_a(1'b0, 1'b0, 8'h00, 32'h0, 1'b0); exp_b_q.push_back(32'h05050505); cyc(2'b01);
    idle_cyc();

    // Test 6: reset in the middle of an A locked write burst
    drv_a(1'b1, 1'b1, 8'h30, 32'h11112222, 1'b1);
    exp_w_q.push_back({8'h30, 32'h11112222}); cyc(2'b10);
    drv_a(1'b1, 1'b1, 8'h34, 32'h33334444, 1'b1);
    exp_w_q.push_back({8'h34, 32'h33334444}); cyc(2'b10);
    drv_a(1'b1, 1'b1, 8'h38, 32'h55556666, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midburst_rst_a_gnt", {63'd0, a_gnt}, 64'd0);
    chk("midburst_rst_mem_we", {63'd0, mem_write_enable}, 64'd0);
    @(posedge clock);
    #1;
    chk("midburst_rst_rvalid", {62'd0, a_rvalid, b_rvalid}, 64'd0);
    drv_a(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    #5;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    drv_a(1'b1, 1'b0, 8'h38, 32'h0, 1'b0); drv_b(1'b1, 1'b0, 8'h0C, 32'h0, 1'b0);
    exp_a_q.push_back(32'h0E0E0E0E); cyc(2'b10);
    drv_a(1'b1, 1'b0, 8'h34, 32'h0, 1'b0);
    exp_b_q.push_back(32'h03030303); cyc(2'b01);
    drv_b(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    exp_a_q.push_back(32'h33334444); cyc(2'b10);
    idle_cyc();
    idle_cyc();

    chk("exp_a_drained", 64'(exp_a_q.size()), 64'd0);
    chk("exp_b_drained", 64'(exp_b_q.size()), 64'd0);
    chk("exp_w_drained", 64'(exp_w_q.size()), 64'd0);
    chk("exp_g_drained", 64'(exp_g_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
